// File: rtl/rf_hazard_scoreboard_pkg.sv
// ============================================================================
// rf_hazard_scoreboard_pkg : shared register-select types and sizing
// Rev 1.0
// ============================================================================
`default_nettype none

package rf_hazard_scoreboard_pkg;

  localparam int NUM_REGS_DEFAULT = 8;
  localparam int REG_SEL_W        = 3;
  localparam int CNT_W_DEFAULT    = 2;

  typedef logic [REG_SEL_W-1:0] reg_sel_t;

  localparam reg_sel_t LINK_REG = 3'd7;

endpackage

`default_nettype wire

// File: rtl/rf_hazard_scoreboard_pending_counter.sv
// ============================================================================
// rf_pending_counter : saturating-free up/down count of in-flight writes
// Rev 1.0
// ============================================================================
`default_nettype none

module rf_pending_counter
  import rf_hazard_scoreboard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             full,
  output logic             underflow_attempt
);

  localparam logic [CNT_W-1:0] c_max = '1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_dec_ok;
  logic             w_inc_ok;

  // A writeback to an empty counter is dropped here and reported upward.
  assign w_dec_ok = dec & (r_cnt != '0);
  assign w_inc_ok = inc & (r_cnt != c_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (w_inc_ok && !w_dec_ok) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (w_dec_ok && !inc) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign count             = r_cnt;
  assign nonzero           = (r_cnt != '0);
  assign full              = (r_cnt == c_max);
  assign underflow_attempt = dec & (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/rf_hazard_scoreboard.sv
// ============================================================================
// rf_hazard_scoreboard : per-register pending-write tracking and decode stall
// Rev 1.0
// ============================================================================
`default_nettype none

module rf_hazard_scoreboard
  import rf_hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS  = NUM_REGS_DEFAULT,
  parameter int CNT_W     = CNT_W_DEFAULT,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                rs_used,
  input  reg_sel_t            rs_sel,
  input  logic                rt_used,
  input  reg_sel_t            rt_sel,
  input  logic                wr_en,
  input  reg_sel_t            wr_sel,
  input  logic                wb_en,
  input  reg_sel_t            wb_sel,
  input  logic                flush,
  output logic                stall,
  output logic                issue_fire,
  output logic [NUM_REGS-1:0] busy,
  output logic                err
);

  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_dec;
  logic [NUM_REGS-1:0] w_nonzero;
  logic [NUM_REGS-1:0] w_full;
  logic [NUM_REGS-1:0] w_underflow;
  logic [NUM_REGS-1:0] w_eff_nz;
  logic [CNT_W-1:0]    w_cnt [NUM_REGS];

  logic w_haz_rs;
  logic w_haz_rt;
  logic w_haz_full;
  logic r_err;

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      logic w_wb_hit;

      assign w_wb_hit = wb_en & (wb_sel == reg_sel_t'(i));
      assign w_inc[i] = issue_fire & wr_en & (wr_sel == reg_sel_t'(i));
      assign w_dec[i] = w_wb_hit;

      // A single outstanding write retiring this cycle is forwarded by the
      // register file, so it no longer counts as a hazard for readers.
      assign w_eff_nz[i] = w_nonzero[i] &
                           ~(WB_BYPASS & w_wb_hit & (w_cnt[i] == CNT_W'(1)));

      rf_pending_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk               (clk),
        .rst               (rst),
        .inc               (w_inc[i]),
        .dec               (w_dec[i]),
        .clear             (flush),
        .count             (w_cnt[i]),
        .nonzero           (w_nonzero[i]),
        .full              (w_full[i]),
        .underflow_attempt (w_underflow[i])
      );
    end
  endgenerate

  assign w_haz_rs   = rs_used & w_eff_nz[rs_sel];
  assign w_haz_rt   = rt_used & w_eff_nz[rt_sel];
  assign w_haz_full = wr_en & w_full[wr_sel];

  // Gated by rst so decode is released the instant reset asserts.
  assign stall      = ~rst & issue_valid & ~flush & (w_haz_rs | w_haz_rt | w_haz_full);
  assign issue_fire = ~rst & issue_valid & ~flush & ~stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (|w_underflow) begin
      r_err <= 1'b1;
    end
  end

  assign busy = w_nonzero;
  assign err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_rf_hazard_scoreboard.sv
// ============================================================================
// tb_rf_hazard_scoreboard : scoreboard-driven self-checking bench
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rf_hazard_scoreboard;

  logic       clk;
  logic       rst;
  logic       issue_valid;
  logic       rs_used;
  logic [2:0] rs_sel;
  logic       rt_used;
  logic [2:0] rt_sel;
  logic       wr_en;
  logic [2:0] wr_sel;
  logic       wb_en;
  logic [2:0] wb_sel;
  logic       flush;
  logic       stall;
  logic       issue_fire;
  logic [7:0] busy;
  logic       err;

  localparam bit WB_BYPASS = 1'b1;
  localparam int MAXC      = 3;

  typedef struct {
    string      tag;
    logic [7:0] a;
    logic [7:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   mcnt[8];
  bit   merr;

  rf_hazard_scoreboard #(
    .NUM_REGS  (8),
    .CNT_W     (2),
    .WB_BYPASS (WB_BYPASS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .rs_used     (rs_used),
    .rs_sel      (rs_sel),
    .rt_used     (rt_used),
    .rt_sel      (rt_sel),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wb_en       (wb_en),
    .wb_sel      (wb_sel),
    .flush       (flush),
    .stall       (stall),
    .issue_fire  (issue_fire),
    .busy        (busy),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_eff_nz(input int r);
    if (mcnt[r] == 0) return 1'b0;
    if (WB_BYPASS && wb_en && (int'(wb_sel) == r) && mcnt[r] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_stall();
    bit a, b, c;
    a = rs_used && m_eff_nz(int'(rs_sel));
    b = rt_used && m_eff_nz(int'(rt_sel));
    c = wr_en && (mcnt[wr_sel] == MAXC);
    return issue_valid && !flush && (a || b || c);
  endfunction

  function automatic logic [7:0] m_busy();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = (mcnt[i] != 0);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mcnt[i] = 0;
    merr = 1'b0;
  endtask

  task automatic drive(input bit iv, input bit rsu, input int rss, input bit rtu, input int rts,
                       input bit we, input int ws, input bit wbe, input int wbs, input bit fl);
    issue_valid = iv;  rs_used = rsu; rs_sel = 3'(rss);
    rt_used     = rtu; rt_sel  = 3'(rts);
    wr_en       = we;  wr_sel  = 3'(ws);
    wb_en       = wbe; wb_sel  = 3'(wbs);
    flush       = fl;
  endtask

  // One full cycle: combinational decision checked mid-cycle, state after the edge.
  task automatic cycle(input string tag, input bit iv, input bit rsu, input int rss,
                       input bit rtu, input int rts, input bit we, input int ws,
                       input bit wbe, input int wbs, input bit fl);
    exp_t e, o;
    bit   s, f;
    @(negedge clk);
    drive(iv, rsu, rss, rtu, rts, we, ws, wbe, wbs, fl);
    s = m_stall();
    f = iv && !s && !fl;
    e.tag = {tag, ".comb"}; e.a = {7'd0, s}; e.b = {7'd0, f};
    exp_q.push_back(e);
    #1;
    o = exp_q.pop_front();
    check({o.tag, ".stall"}, {31'd0, stall}, {24'd0, o.a});
    check({o.tag, ".fire"},  {31'd0, issue_fire}, {24'd0, o.b});
    if (wbe && mcnt[wbs] == 0) merr = 1'b1;
    if (fl) begin
      for (int i = 0; i < 8; i++) mcnt[i] = 0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        bit inc, dec;
        inc = f && we && ws == i;
        dec = wbe && wbs == i && mcnt[i] != 0;
        if (inc && !dec) mcnt[i]++;
        else if (dec && !inc) mcnt[i]--;
      end
    end
    e.tag = {tag, ".seq"}; e.a = m_busy(); e.b = {7'd0, merr};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o = exp_q.pop_front();
    check({o.tag, ".busy"}, {24'd0, busy}, {24'd0, o.a});
    check({o.tag, ".err"},  {31'd0, err},  {24'd0, o.b});
  endtask

  task automatic idle(input string tag);
    cycle(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check("reset.busy",  {24'd0, busy}, 32'h0);
    check("reset.err",   {31'd0, err}, 32'h0);
    check("reset.stall", {31'd0, stall}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // RAW on R3, then bypassed by same-cycle writeback
    cycle("wr_r3",   1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    check("r3.busy", {24'd0, busy}, 32'h08);
    cycle("rd_r3",   1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    cycle("rd_r3_wb", 1, 1, 3, 0, 0, 0, 0, 1, 3, 0);
    check("r3.clear", {24'd0, busy}, 32'h00);

    // Fill R2 to max, fourth write stalls
    for (int k = 0; k < 3; k++) cycle("wr_r2", 1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    check("r2.cnt3", mcnt[2], 32'd3);
    cycle("wr_r2_full", 1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    cycle("wb_r2",      0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
    cycle("wr_r2_ok",   1, 0, 0, 0, 0, 1, 2, 0, 0, 0);

    // rt hazard on R2 (cnt 3, writeback does not hide it)
    cycle("rt_r2", 1, 0, 0, 1, 2, 0, 0, 1, 2, 0);

    // Same-cycle issue and writeback on R5
    cycle("wr_r5",     1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    cycle("wr_wb_r5",  1, 0, 0, 0, 0, 1, 5, 1, 5, 0);
    check("r5.hold", {31'd0, busy[5]}, 32'h1);

    // Self-dependency on R4 with nothing pending
    cycle("self_r4", 1, 1, 4, 0, 0, 1, 4, 0, 0, 0);
    cycle("wb_r4",   0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
    check("err.before", {31'd0, err}, 32'h0);

    // Underflow writeback to empty R4 latches err
    cycle("uflow_r4", 0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
    check("err.set", {31'd0, err}, 32'h1);
    cycle("nop_busy", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle("idle_err");
    check("err.sticky", {31'd0, err}, 32'h1);

    // Flush clears everything
    cycle("flush0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle("wr_r1",  1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    cycle("wr_r6",  1, 0, 0, 0, 0, 1, 6, 0, 0, 0);
    cycle("wr_r7",  1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    check("flush.pre", {24'd0, busy}, 32'hC2);
    cycle("flush1", 1, 1, 1, 0, 0, 1, 3, 1, 6, 1);
    check("flush.post", {24'd0, busy}, 32'h00);

    // Constrained random traffic against the model
    for (int k = 0; k < 60; k++) begin
      cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
            1'($urandom_range(0, 1)), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
            ($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset in the middle of a stall
    cycle("flush2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle("wr_r0a", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    cycle("wr_r0b", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("arst.stall_pre", {31'd0, stall}, 32'h1);
    check("arst.busy_pre",  {24'd0, busy},  32'h01);
    #1;
    rst = 1'b1;
    #1;
    check("arst.stall", {31'd0, stall}, 32'h0);
    check("arst.fire",  {31'd0, issue_fire}, 32'h0);
    check("arst.busy",  {24'd0, busy}, 32'h00);
    check("arst.err",   {31'd0, err}, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle("post_rst", 1, 1, 0, 0, 0, 1, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rf_hazard_scoreboard.md
Name: rf_hazard_scoreboard

Overview:
- Per-register pending-write scoreboard sitting beside the decode stage's register file (8 x 16-bit, R0-R7).
- Tracks writes issued from decode but not yet written back.
- Stalls decode when an instruction reads a register with a write in flight, or would overflow that register's pending count.
- Flags protocol errors into the decode err path.

Parameters:
- NUM_REGS, 8, number of architectural registers; select width is clog2(NUM_REGS)=3.
- CNT_W, 2, width of each pending counter; max in-flight writes per register = 2^CNT_W - 1.
- WB_BYPASS, 1, 1 = a same-cycle writeback to a source register clears the hazard (register file forwards write data to reads); 0 = always stall on a nonzero count.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- issue_valid  in  1  decode holds a valid instruction this cycle
- rs_used  in  1  instruction reads instruction[10:8]
- rs_sel  in  3  source register 1
- rt_used  in  1  instruction reads instruction[7:5]
- rt_sel  in  3  source register 2
- wr_en  in  1  instruction writes a register (control RegWrite)
- wr_sel  in  3  destination register (RegDst mux output; R7 for link)
- wb_en  in  1  writeback stage writes the register file this cycle
- wb_sel  in  3  register being written back
- flush  in  1  squash all in-flight instructions (branch/jump redirect)
- stall  out  1  hold decode; instruction not issued this cycle
- issue_fire  out  1  instruction accepted = issue_valid & ~stall
- busy  out  8  bit i = pending count of Ri nonzero (registered view)
- err  out  1  sticky protocol error

Behaviour:
- Reset (async, rst=1): all counters 0, busy=0, err=0. stall and issue_fire are 0 while rst is high.
- State: cnt[i] (CNT_W bits) for each i in 0..7. busy[i] = |cnt[i].
- Effective count for hazard checks:
  - eff[i] = cnt[i] - 1 when WB_BYPASS=1, wb_en=1, wb_sel==i and cnt[i]!=0.
  - Otherwise eff[i] = cnt[i].
- stall (combinational, same cycle) = issue_valid & ~flush & (A | B | C), where:
  - A = rs_used & eff[rs_sel]!=0
  - B = rt_used & eff[rt_sel]!=0
  - C = wr_en & cnt[wr_sel]==MAX, with MAX = 2^CNT_W - 1
- issue_fire = issue_valid & ~stall & ~flush. Latency 0: the decision is made in the same cycle.
- Next-state update for each register i, on the clock edge:
  - inc = issue_fire & wr_en & wr_sel==i
  - dec = wb_en & wb_sel==i & cnt[i]!=0
  - inc & dec: cnt unchanged.
  - inc only: cnt+1.
  - dec only: cnt-1.
  - Neither: hold.
- Underflow: wb_en with cnt[wb_sel]==0 sets err=1. The counter stays 0.
- Overflow cannot occur; it is blocked by the C term of stall.
- flush: all counters go to 0 at the next edge. An issue or writeback in the same cycle is ignored for counting. Writes already at writeback are the pipeline's responsibility to squash.
- err is sticky and clears only on rst.
- Self-dependency (wr_sel==rs_sel, no pending write): no stall. The instruction issues and cnt becomes 1.
- Mid-operation reset: counters clear immediately. stall drops asynchronously.
- An instruction with rs_used=rt_used=wr_en=0 (NOP, HALT) never stalls unless flush=1; issue_fire=0 during flush.

Decomposition:
- Shared package holds:
  - NUM_REGS and REG_SEL_W=3
  - LINK_REG=3'd7
  - a typedef for the register select
  - default CNT_W
- One natural sub-module: rf_pending_counter. It is a single CNT_W up/down counter with inc, dec, clear and async rst. It outputs nonzero, full and underflow_attempt, and is instantiated NUM_REGS times.

Test Plan:
- Reset, then issue wr_en=1 wr_sel=3. Next instruction rs_used rs_sel=3 -> stall=1, busy=8'h08. wb_en wb_sel=3 with WB_BYPASS=1 -> stall=0 that cycle and busy=0 after the edge.
- Issue three writes to R2 with no writeback -> cnt=3. A fourth write to R2 -> stall=1 and issue_fire=0. wb_en wb_sel=2 -> cnt=2, next issue proceeds.
- Same-cycle issue (wr_sel=5) and wb_en (wb_sel=5) with cnt[5]=1 -> cnt[5] stays 1, err=0.
- wb_en wb_sel=4 with cnt[4]=0 -> err=1 next cycle and stays 1 through further traffic until rst.
- Pending writes on R1, R6, R7 (busy=8'hC2), then flush=1 with issue_valid=1 -> issue_fire=0, busy=8'h00 next cycle.
- Assert rst mid-stall (cnt[0]=2, stall=1) -> stall=0 and busy=0 immediately, without waiting for a clock edge.
